// File: rtl/pe_row_feeder_pkg.sv
// pe_row_feeder_pkg: definitions shared by the PE row feeder and the PE array.
//   feeder_state_t          : sequencer states (IDLE, LOAD_W, STREAM, DRAIN)
//   SIMD_8 / SIMD_16        : encodings of the PE simd_mode input
//   PE_DATA_W/SIGN_W/SUM_W  : widths of the PE matrix data, sign and partial sum
package pe_row_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  localparam logic SIMD_8  = 1'b0;
  localparam logic SIMD_16 = 1'b1;

  localparam int unsigned PE_DATA_W = 16;
  localparam int unsigned PE_SIGN_W = 2;
  localparam int unsigned PE_SUM_W  = 32;

endpackage

// File: rtl/pe_feeder_ctrl.sv
// pe_feeder_ctrl: job sequencer for pe_row_feeder (FSM plus weight, vector and
// drain counters).
//   clk, rst          : clock, synchronous active-high reset
//   start             : job start, honoured only in IDLE
//   cfg_vec_count     : matrix beats in the job, latched on an accepted start
//   w_valid, m_valid  : upstream valid of the weight / matrix streams
//   state_next        : next state, for registering state-dependent datapath outputs
//   start_accept      : start honoured this cycle
//   w_fire, m_fire    : weight / matrix beat accepted this cycle
//   w_idx             : index of the PE the current weight beat belongs to
//   w_ready, m_ready  : registered stream ready outputs
//   en, busy, done    : registered PE enable, busy flag, completion pulse
module pe_feeder_ctrl
  import pe_row_feeder_pkg::*;
#(
  parameter int unsigned N_PE  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             cfg_vec_count,
  input  logic                         w_valid,
  input  logic                         m_valid,
  output feeder_state_t                state_next,
  output logic                         start_accept,
  output logic                         w_fire,
  output logic                         m_fire,
  output logic [$clog2(N_PE+1)-1:0]    w_idx,
  output logic                         w_ready,
  output logic                         m_ready,
  output logic                         en,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned PCNT_W = $clog2(N_PE + 1);
  localparam logic [PCNT_W-1:0] LAST_PE = PCNT_W'(N_PE - 1);

  feeder_state_t     state;
  logic [PCNT_W-1:0] w_cnt, w_cnt_d;
  logic [PCNT_W-1:0] d_cnt, d_cnt_d;
  logic [CNT_W-1:0]  v_cnt, v_cnt_d;
  logic [CNT_W-1:0]  vec_count, vec_count_d;

  always_comb begin
    state_next   = state;
    w_cnt_d      = w_cnt;
    d_cnt_d      = d_cnt;
    v_cnt_d      = v_cnt;
    vec_count_d  = vec_count;
    start_accept = 1'b0;
    // Readies are only ever high in their own state, so a fire implies the state.
    w_fire       = w_valid & w_ready;
    m_fire       = m_valid & m_ready;
    w_idx        = w_cnt;

    unique case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = LOAD_W;
          w_cnt_d      = '0;
          d_cnt_d      = '0;
          v_cnt_d      = '0;
          vec_count_d  = cfg_vec_count;
        end
      end
      LOAD_W: begin
        if (w_fire) begin
          w_cnt_d = w_cnt + 1'b1;
          if (w_cnt == LAST_PE) begin
            d_cnt_d    = '0;
            state_next = (vec_count == '0) ? DRAIN : STREAM;
          end
        end
      end
      STREAM: begin
        if (m_fire) begin
          v_cnt_d = v_cnt + 1'b1;
          if (v_cnt == vec_count - CNT_W'(1)) begin
            d_cnt_d    = '0;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (d_cnt == LAST_PE) begin
          state_next = IDLE;
        end else begin
          d_cnt_d = d_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the
  // state register; done therefore marks the final DRAIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_cnt     <= '0;
      d_cnt     <= '0;
      v_cnt     <= '0;
      vec_count <= '0;
      w_ready   <= 1'b0;
      m_ready   <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      w_cnt     <= w_cnt_d;
      d_cnt     <= d_cnt_d;
      v_cnt     <= v_cnt_d;
      vec_count <= vec_count_d;
      w_ready   <= (state_next == LOAD_W);
      m_ready   <= (state_next == STREAM);
      en        <= (state_next != IDLE);
      busy      <= (state_next != IDLE);
      done      <= (state_next == DRAIN) && (d_cnt_d == LAST_PE);
    end
  end

endmodule

// File: rtl/pe_row_feeder.sv
// pe_row_feeder: drives one row of the systolic PE chain. Per job it loads one
// weight into each of N_PE PEs, streams cfg_vec_count matrix beats into PE 0
// with the bias on sum_in, drains the chain for N_PE cycles and pulses done.
//   clk, rst                      : clock, synchronous active-high reset
//   start, cfg_*                  : job start and configuration (latched on start)
//   w_valid/w_ready/w_data        : weight stream in
//   m_valid/m_ready/m_data/m_sign : matrix stream in
//   en, simd_mode                 : PE enable and mode
//   weight_write_en, weight_data  : one-hot weight strobe and broadcast weight
//   matrix_data/sign/valid        : row input to PE 0
//   sum_in                        : partial-sum seed into PE 0
//   busy, done                    : job in progress, one-cycle completion pulse
//   stall_cycles                  : only with PE_FEEDER_STALL_CNT_EN defined;
//                                   STREAM cycles spent waiting on m_valid
module pe_row_feeder
  import pe_row_feeder_pkg::*;
#(
  parameter int unsigned N_PE  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cfg_simd_mode,
  input  logic [CNT_W-1:0]     cfg_vec_count,
  input  logic [PE_SUM_W-1:0]  cfg_bias,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [PE_DATA_W-1:0] w_data,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [PE_DATA_W-1:0] m_data,
  input  logic [PE_SIGN_W-1:0] m_sign,
  output logic                 en,
  output logic                 simd_mode,
  output logic [N_PE-1:0]      weight_write_en,
  output logic [PE_DATA_W-1:0] weight_data,
  output logic [PE_DATA_W-1:0] matrix_data,
  output logic [PE_SIGN_W-1:0] matrix_sign,
  output logic                 matrix_valid,
  output logic [PE_SUM_W-1:0]  sum_in,
  output logic                 busy,
  output logic                 done
`ifdef PE_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int unsigned PCNT_W = $clog2(N_PE + 1);
  localparam logic [N_PE-1:0] PE_ONE = N_PE'(1);

  feeder_state_t         state_next;
  logic                  start_accept;
  logic                  w_fire;
  logic                  m_fire;
  logic [PCNT_W-1:0]     w_idx;
  logic [PE_SUM_W-1:0]   bias;

  pe_feeder_ctrl #(
    .N_PE  (N_PE),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_vec_count (cfg_vec_count),
    .w_valid       (w_valid),
    .m_valid       (m_valid),
    .state_next    (state_next),
    .start_accept  (start_accept),
    .w_fire        (w_fire),
    .m_fire        (m_fire),
    .w_idx         (w_idx),
    .w_ready       (w_ready),
    .m_ready       (m_ready),
    .en            (en),
    .busy          (busy),
    .done          (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      simd_mode       <= SIMD_8;
      bias            <= '0;
      weight_write_en <= '0;
      weight_data     <= '0;
      matrix_data     <= '0;
      matrix_sign     <= '0;
      matrix_valid    <= 1'b0;
      sum_in          <= '0;
    end else begin
      if (start_accept) begin
        simd_mode <= cfg_simd_mode ? SIMD_16 : SIMD_8;
        bias      <= cfg_bias;
      end

      weight_write_en <= '0;
      if (w_fire) begin
        weight_write_en <= PE_ONE << w_idx;
        weight_data     <= w_data;
      end

      // Cycles without an accepted beat present a zeroed bubble to PE 0.
      if (m_fire) begin
        matrix_data  <= m_data;
        matrix_sign  <= m_sign;
        matrix_valid <= 1'b1;
      end else begin
        matrix_data  <= '0;
        matrix_sign  <= '0;
        matrix_valid <= 1'b0;
      end

      sum_in <= (state_next == STREAM) ? bias : '0;
    end
  end

`ifdef PE_FEEDER_STALL_CNT_EN
  // m_ready is high exactly in STREAM, so ready-without-valid is a stall cycle.
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      stall_cycles <= '0;
    end else if (m_ready && !m_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_row_feeder.sv
module tb_pe_row_feeder;

  localparam int unsigned NPE = 4;
  localparam int unsigned CW  = 16;

  logic           clk = 1'b0;
  logic           rst, start, cfg_simd_mode;
  logic [CW-1:0]  cfg_vec_count;
  logic [31:0]    cfg_bias;
  logic           w_valid, w_ready;
  logic [15:0]    w_data;
  logic           m_valid, m_ready;
  logic [15:0]    m_data;
  logic [1:0]     m_sign;
  logic           en, simd_mode;
  logic [NPE-1:0] weight_write_en;
  logic [15:0]    weight_data, matrix_data;
  logic [1:0]     matrix_sign;
  logic           matrix_valid;
  logic [31:0]    sum_in;
  logic           busy, done;
`ifdef PE_FEEDER_STALL_CNT_EN
  logic [31:0]    stall_cycles;
`endif

  pe_row_feeder #(
    .N_PE  (NPE),
    .CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_simd_mode   (cfg_simd_mode),
    .cfg_vec_count   (cfg_vec_count),
    .cfg_bias        (cfg_bias),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .w_data          (w_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_sign          (m_sign),
    .en              (en),
    .simd_mode       (simd_mode),
    .weight_write_en (weight_write_en),
    .weight_data     (weight_data),
    .matrix_data     (matrix_data),
    .matrix_sign     (matrix_sign),
    .matrix_valid    (matrix_valid),
    .sum_in          (sum_in),
    .busy            (busy),
    .done            (done)
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [NPE-1:0] wen; logic [15:0] data; int cyc_at; } w_exp_t;
  typedef struct { logic [15:0] data; logic [1:0] sign; int cyc_at; } m_exp_t;
  typedef struct { int cyc_at; logic [31:0] stall; } d_exp_t;

  w_exp_t wq[$];
  m_exp_t mq[$];
  d_exp_t dq[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int last_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expected record whenever the DUT presents an output.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (weight_write_en != '0) begin
          if (wq.size() == 0) check("unexp_wen", 64'(weight_write_en), 64'd0);
          else begin
            w_exp_t e;
            e = wq.pop_front();
            check("wen", 64'(weight_write_en), 64'(e.wen));
            check("wdata", 64'(weight_data), 64'(e.data));
            check("wen_cycle", 64'(cyc), 64'(e.cyc_at));
          end
        end
        if (matrix_valid) begin
          if (mq.size() == 0) check("unexp_mvalid", 64'(matrix_valid), 64'd0);
          else begin
            m_exp_t e;
            e = mq.pop_front();
            check("mdata", 64'(matrix_data), 64'(e.data));
            check("msign", 64'(matrix_sign), 64'(e.sign));
            check("mvalid_cycle", 64'(cyc), 64'(e.cyc_at));
          end
        end else if (busy) begin
          check("bubble_zero", 64'({matrix_data, matrix_sign}), 64'd0);
        end
        if (done) begin
          if (dq.size() == 0) check("unexp_done", 64'(done), 64'd0);
          else begin
            d_exp_t e;
            e = dq.pop_front();
            check("done_cycle", 64'(cyc), 64'(e.cyc_at));
`ifdef PE_FEEDER_STALL_CNT_EN
            check("stall_at_done", 64'(stall_cycles), 64'(e.stall));
`endif
          end
        end
      end
    end
  end

  task automatic do_start(input logic [CW-1:0] cnt, input logic [31:0] bias, input logic simd);
    start = 1'b1; cfg_vec_count = cnt; cfg_bias = bias; cfg_simd_mode = simd;
    step;
    start = 1'b0;
    check("simd_mode", 64'(simd_mode), 64'(simd));
    check("busy_after_start", 64'({busy, en, w_ready}), 64'b111);
`ifdef PE_FEEDER_STALL_CNT_EN
    check("stall_clear_on_start", 64'(stall_cycles), 64'd0);
`endif
  endtask

  task automatic send_weight(input logic [15:0] d, input logic [NPE-1:0] exp_wen);
    int k = 0;
    w_valid = 1'b1; w_data = d;
    while (!w_ready && k < 20) begin step; k++; end
    if (!w_ready) check("w_ready_wait", 64'(w_ready), 64'd1);
    else begin
      wq.push_back('{exp_wen, d, cyc + 1});
      last_acc = cyc;
    end
    step;
    w_valid = 1'b0;
  endtask

  task automatic send_matrix(input logic [15:0] d, input logic [1:0] s, input logic [31:0] exp_sum);
    int k = 0;
    m_valid = 1'b1; m_data = d; m_sign = s;
    while (!m_ready && k < 20) begin step; k++; end
    if (!m_ready) check("m_ready_wait", 64'(m_ready), 64'd1);
    else begin
      check("sum_in_stream", 64'(sum_in), 64'(exp_sum));
      mq.push_back('{d, s, cyc + 1});
      last_acc = cyc;
    end
    step;
    m_valid = 1'b0;
  endtask

  // done is expected NPE cycles after the last accepted beat.
  task automatic finish_job(input logic [31:0] exp_stall, input bit start_on_done, output bit saw_mready);
    int k = 0;
    saw_mready = 1'b0;
    dq.push_back('{last_acc + NPE, exp_stall});
    while (!done && k < 40) begin
      if (m_ready) saw_mready = 1'b1;
      step; k++;
    end
    if (!done) begin
      check("done_wait", 64'(done), 64'd1);
      dq.delete();
    end else if (start_on_done) begin
      start = 1'b1; cfg_vec_count = 16'd1; cfg_bias = 32'h1;
    end
    step;
    start = 1'b0;
    check("busy_after_done", 64'(busy), 64'd0);
    check("idle_ctrl", 64'({w_ready, m_ready, en, done}), 64'd0);
    check("sum_in_idle", 64'(sum_in), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mr;
    rst = 1'b1; start = 1'b0; cfg_simd_mode = 1'b0; cfg_vec_count = '0; cfg_bias = '0;
    w_valid = 1'b0; w_data = '0; m_valid = 1'b0; m_data = '0; m_sign = '0;
    repeat (3) step;
    rst = 1'b0;
    repeat (5) step;
    check("rst_ready", 64'({w_ready, m_ready}), 64'd0);
    check("rst_ctrl", 64'({en, busy, done, simd_mode}), 64'd0);
    check("rst_weight", 64'({weight_write_en, weight_data}), 64'd0);
    check("rst_matrix", 64'({matrix_data, matrix_sign, matrix_valid}), 64'd0);
    check("rst_sum", 64'(sum_in), 64'd0);
`ifdef PE_FEEDER_STALL_CNT_EN
    check("rst_stall", 64'(stall_cycles), 64'd0);
`endif
    mon_en = 1'b1;

    // Job 1: 3 vectors, one gap -> matrix_valid 1,0,1,1
    do_start(16'd3, 32'h0000_0100, 1'b1);
    send_weight(16'h0011, 4'b0001);
    send_weight(16'h0022, 4'b0010);
    send_weight(16'h0033, 4'b0100);
    send_weight(16'h0044, 4'b1000);
    send_matrix(16'h1234, 2'b01, 32'h0000_0100);
    step;
    send_matrix(16'hABCD, 2'b10, 32'h0000_0100);
    send_matrix(16'h00FF, 2'b11, 32'h0000_0100);
    finish_job(32'd1, 1'b0, mr);

    // Job 2: zero vectors, LOAD_W goes straight to DRAIN
    do_start(16'd0, 32'h0000_DEAD, 1'b0);
    send_weight(16'hA5A5, 4'b0001);
    send_weight(16'h5A5A, 4'b0010);
    send_weight(16'hFFFF, 4'b0100);
    send_weight(16'h0001, 4'b1000);
    finish_job(32'd0, 1'b0, mr);
    check("vec0_no_mready", 64'(mr), 64'd0);

    // Job 3: reset after 1 of 5 beats
    do_start(16'd5, 32'h0000_0055, 1'b1);
    send_weight(16'h1111, 4'b0001);
    send_weight(16'h2222, 4'b0010);
    send_weight(16'h3333, 4'b0100);
    send_weight(16'h4444, 4'b1000);
    send_matrix(16'h0F0F, 2'b01, 32'h0000_0055);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("abort_ctrl", 64'({w_ready, m_ready, en, busy, done, simd_mode}), 64'd0);
    check("abort_weight", 64'({weight_write_en, weight_data}), 64'd0);
    check("abort_matrix", 64'({matrix_data, matrix_sign, matrix_valid, sum_in}), 64'd0);
    repeat (8) step;
    check("abort_still_idle", 64'(busy), 64'd0);

    // Job 4: 2 vectors with 2 gap cycles; start during done is ignored
    do_start(16'd2, 32'hBEEF_0001, 1'b0);
    send_weight(16'h0101, 4'b0001);
    send_weight(16'h0202, 4'b0010);
    send_weight(16'h0303, 4'b0100);
    send_weight(16'h0404, 4'b1000);
    send_matrix(16'hCAFE, 2'b10, 32'hBEEF_0001);
    step;
    step;
    send_matrix(16'h0001, 2'b00, 32'hBEEF_0001);
    finish_job(32'd2, 1'b1, mr);
    step;
    check("start_on_done_ignored", 64'({busy, w_ready}), 64'd0);

    // Job 5: single vector, normal completion after the earlier abort
    do_start(16'd1, 32'h0000_0007, 1'b1);
    send_weight(16'h8000, 4'b0001);
    send_weight(16'h4000, 4'b0010);
    send_weight(16'h2000, 4'b0100);
    send_weight(16'h1000, 4'b1000);
    send_matrix(16'h8001, 2'b11, 32'h0000_0007);
    finish_job(32'd0, 1'b0, mr);

    repeat (3) step;
    check("queues_drained", 64'(wq.size() + mq.size() + dq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
